fsk_bit_scheduler: RTL and testbench

- Sequences the FSK/OOK DDS by driving its rf_data symbol input.
- Accepts bytes over a valid/ready stream into a small FIFO and serializes them LSB-first.
- Each bit is held for a programmable number of clk cycles, so the DDS switches between freq0 and freq1 at a controlled baud rate.
- Sits between the byte source (UART/host logic) and the DDS top level.

---
 rtl/fsk_bit_scheduler_pkg.sv | 11 +
 rtl/fsk_bit_scheduler_sync_fifo.sv | 55 +++++
 rtl/fsk_bit_scheduler.sv | 136 +++++++++++++
 tb/tb_fsk_bit_scheduler.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_bit_scheduler_pkg.sv
// Shared definitions for the FSK bit scheduler: byte width and FSM state encoding.
package fsk_bit_scheduler_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/fsk_bit_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy count. Pushes into a full FIFO and pops
// from an empty FIFO are ignored. Read data is the head entry, valid
// whenever empty_o is low, so a byte pushed this cycle is poppable next cycle.
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic [WIDTH-1:0]       wdata_i,
   input  logic                   pop_i,
   output logic [WIDTH-1:0]       rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]    level_q;
   logic             push_ok, pop_ok;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign rdata_o = mem_q[rd_ptr_q];
   assign level_o = level_q;

   // Storage array: written on accepted pushes, never reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // Pointers and occupancy; simultaneous push and pop leave the level unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push_ok && !pop_ok)      level_q <= level_q + LW'(1);
         else if (pop_ok && !push_ok) level_q <= level_q - LW'(1);
      end
   end

endmodule

// File: rtl/fsk_bit_scheduler.sv
// Byte-to-symbol scheduler for the FSK/OOK DDS. Bytes enter a FIFO over a
// valid/ready stream and leave LSB-first on rf_data, each bit held for
// baud_div+1 cycles. Consecutive bytes are sent with no gap while enable
// stays high and the FIFO has data.
//
// Input stream handshake: a byte transfers on a rising clk edge where
// in_valid && in_ready are both high; in_ready is !full, independent of
// in_valid, and in_data must be stable while in_valid is high.
import fsk_bit_scheduler_pkg::*;

module fsk_bit_scheduler #(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_W      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [DIV_W-1:0]            baud_div,
   input  logic [BYTE_W-1:0]           in_data,
   input  logic                        in_valid,
   output logic                        in_ready,
   output logic                        rf_data,
   output logic                        bit_strobe,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(FIFO_DEPTH):0] level,
   output state_e                      dbg_state
);

   state_e            state_q, state_d;
   logic [BYTE_W-1:0] shreg_q, shreg_d;
   logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
   logic [DIV_W-1:0]  div_lat_q, div_lat_d;
   logic [2:0]        bit_cnt_q, bit_cnt_d;
   logic              rf_q, rf_d;
   logic              strobe_q, strobe_d;
   logic              done_q, done_d;

   logic              fifo_full, fifo_empty, can_load, load;
   logic [BYTE_W-1:0] fifo_rdata;

   assign in_ready   = !fifo_full;
   assign can_load   = enable && !fifo_empty;
   assign rf_data    = rf_q;
   assign bit_strobe = strobe_q;
   assign busy       = (state_q == ST_SHIFT);
   assign done       = done_q;
   assign dbg_state  = state_q;

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (in_valid && in_ready),
      .wdata_i (in_data),
      .pop_i   (load),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (level)
   );

   // Next-state logic: bit timing, shifting, byte loads and end-of-stream.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      div_cnt_d = div_cnt_q;
      div_lat_d = div_lat_q;
      bit_cnt_d = bit_cnt_q;
      rf_d      = rf_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      load      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            rf_d = 1'b0;
            if (can_load) load = 1'b1;
         end
         ST_SHIFT: begin
            if (div_cnt_q != '0) begin
               div_cnt_d = div_cnt_q - DIV_W'(1);
            end else if (bit_cnt_q != 3'd7) begin
               shreg_d   = shreg_q >> 1;
               rf_d      = shreg_q[1];
               bit_cnt_d = bit_cnt_q + 3'd1;
               div_cnt_d = div_lat_q;
               strobe_d  = 1'b1;
            end else if (can_load) begin
               load = 1'b1;
            end else begin
               state_d = ST_IDLE;
               rf_d    = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A load (from IDLE or back-to-back at the end of a byte) latches the
      // divider so mid-byte baud_div changes only affect the next byte.
      if (load) begin
         state_d   = ST_SHIFT;
         shreg_d   = fifo_rdata;
         rf_d      = fifo_rdata[0];
         bit_cnt_d = 3'd0;
         div_cnt_d = baud_div;
         div_lat_d = baud_div;
         strobe_d  = 1'b1;
      end
   end

   // State and datapath registers; reset aborts any byte in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         div_cnt_q <= '0;
         div_lat_q <= '0;
         bit_cnt_q <= '0;
         rf_q      <= 1'b0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         div_cnt_q <= div_cnt_d;
         div_lat_q <= div_lat_d;
         bit_cnt_q <= bit_cnt_d;
         rf_q      <= rf_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
      end
   end

endmodule

// File: tb/tb_fsk_bit_scheduler.sv
// Directed bench for fsk_bit_scheduler. Inputs change and outputs are
// sampled 1 ns after each rising edge; "cycle n" is the interval after edge n.
module tb_fsk_bit_scheduler;
   import fsk_bit_scheduler_pkg::*;

   localparam int DIV_W      = 16;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              enable;
   logic [DIV_W-1:0]  baud_div;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              rf_data;
   logic              bit_strobe;
   logic              busy;
   logic              done;
   logic [2:0]        level;
   state_e            dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fsk_bit_scheduler #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .baud_div   (baud_div),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .rf_data    (rf_data),
      .bit_strobe (bit_strobe),
      .busy       (busy),
      .done       (done),
      .level      (level),
      .dbg_state  (dbg_state)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1; enable = 1'b1; baud_div = '0; in_data = '0; in_valid = 1'b0;
      tick;
      tick;
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick;
         n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL reset_rf cyc=%0d got=%b exp=0", i, rf_data); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", i, busy); end
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=1", i, in_ready); end
         n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL reset_level cyc=%0d got=%0d exp=0", i, level); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done cyc=%0d got=%b exp=0", i, done); end
         n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state cyc=%0d got=%0d exp=IDLE", i, dbg_state); end
      end
   endtask

   task automatic test_single_byte;
      logic [7:0] v;
      int         strobes;
      v = 8'hA5;
      strobes = 0;
      baud_div = 16'd3;
      in_data = v; in_valid = 1'b1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL a5_in_ready got=%b exp=1", in_ready); end
      tick;
      in_valid = 1'b0;
      n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL a5_level_t1 got=%0d exp=1", level); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_t1 got=%b exp=0", busy); end
      tick;
      for (int k = 0; k < 32; k++) begin
         n_cmp++; if (rf_data !== v[3'(k/4)]) begin n_err++; $display("FAIL a5_rf k=%0d got=%b exp=%b", k, rf_data, v[3'(k/4)]); end
         n_cmp++; if (bit_strobe !== (k % 4 == 0)) begin n_err++; $display("FAIL a5_strobe k=%0d got=%b exp=%b", k, bit_strobe, (k % 4 == 0)); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL a5_busy k=%0d got=%b exp=1", k, busy); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL a5_done_early k=%0d got=%b exp=0", k, done); end
         if (bit_strobe === 1'b1) strobes++;
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL a5_done got=%b exp=1", done); end
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL a5_rf_end got=%b exp=0", rf_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL a5_busy_end got=%b exp=0", busy); end
      n_cmp++; if (strobes != 8) begin n_err++; $display("FAIL a5_strobe_count got=%0d exp=8", strobes); end
      tick;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL a5_done_pulse got=%b exp=0", done); end
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL a5_rf_idle got=%b exp=0", rf_data); end
   endtask

   task automatic test_back_to_back;
      baud_div = 16'd0;
      in_data = 8'hFF; in_valid = 1'b1;
      tick;
      in_data = 8'h00;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 16; k++) begin
         n_cmp++; if (rf_data !== (k < 8)) begin n_err++; $display("FAIL b2b_rf k=%0d got=%b exp=%b", k, rf_data, (k < 8)); end
         n_cmp++; if (bit_strobe !== 1'b1) begin n_err++; $display("FAIL b2b_strobe k=%0d got=%b exp=1", k, bit_strobe); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy k=%0d got=%b exp=1", k, busy); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_early k=%0d got=%b exp=0", k, done); end
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done got=%b exp=1", done); end
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL b2b_rf_end got=%b exp=0", rf_data); end
      tick;
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b_done_pulse got=%b exp=0", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end got=%b exp=0", busy); end
   endtask

   task automatic test_fifo_full;
      logic [7:0] pat [5];
      logic [7:0] b;
      pat[0] = 8'h3C; pat[1] = 8'hC3; pat[2] = 8'h81; pat[3] = 8'h5A; pat[4] = 8'h96;
      enable = 1'b0; baud_div = 16'd0;
      for (int i = 0; i < 4; i++) begin
         in_data = pat[i]; in_valid = 1'b1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready_fill i=%0d got=%b exp=1", i, in_ready); end
         tick;
      end
      in_data = pat[4];
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready_held i=%0d got=%b exp=0", i, in_ready); end
         n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level_held i=%0d got=%0d exp=4", i, level); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_held i=%0d got=%b exp=0", i, busy); end
         if (i < 3) tick;
      end
      enable = 1'b1;
      tick;
      for (int k = 0; k < 40; k++) begin
         b = pat[k/8];
         if (k == 0) begin
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL full_in_ready_after_pop got=%b exp=1", in_ready); end
            n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL full_level_after_pop got=%0d exp=3", level); end
         end
         if (k == 1) begin
            n_cmp++; if (level !== 3'd4) begin n_err++; $display("FAIL full_level_5th got=%0d exp=4", level); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL full_in_ready_5th got=%b exp=0", in_ready); end
            in_valid = 1'b0;
         end
         n_cmp++; if (rf_data !== b[3'(k%8)]) begin n_err++; $display("FAIL full_rf k=%0d got=%b exp=%b", k, rf_data, b[3'(k%8)]); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL full_done_early k=%0d got=%b exp=0", k, done); end
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL full_done got=%b exp=1", done); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL full_level_end got=%0d exp=0", level); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy_end got=%b exp=0", busy); end
      tick;
   endtask

   task automatic test_enable_drop;
      logic [7:0] b0, b1;
      b0 = 8'h6E; b1 = 8'h21;
      enable = 1'b1; baud_div = 16'd7;
      in_data = b0; in_valid = 1'b1;
      tick;
      in_data = b1;
      tick;
      in_valid = 1'b0;
      for (int k = 0; k < 64; k++) begin
         n_cmp++; if (rf_data !== b0[3'(k/8)]) begin n_err++; $display("FAIL endrop_rf k=%0d got=%b exp=%b", k, rf_data, b0[3'(k/8)]); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL endrop_busy k=%0d got=%b exp=1", k, busy); end
         n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL endrop_level k=%0d got=%0d exp=1", k, level); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL endrop_done_early k=%0d got=%b exp=0", k, done); end
         if (k == 26) enable = 1'b0;
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL endrop_done got=%b exp=1", done); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL endrop_busy_end got=%b exp=0", busy); end
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL endrop_rf_end got=%b exp=0", rf_data); end
      n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL endrop_level_end got=%0d exp=1", level); end
      for (int i = 0; i < 10; i++) begin
         tick;
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL endrop_idle_busy i=%0d got=%b exp=0", i, busy); end
         n_cmp++; if (level !== 3'd1) begin n_err++; $display("FAIL endrop_idle_level i=%0d got=%0d exp=1", i, level); end
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL endrop_idle_done i=%0d got=%b exp=0", i, done); end
         n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL endrop_idle_rf i=%0d got=%b exp=0", i, rf_data); end
      end
      enable = 1'b1;
      tick;
      n_cmp++; if (bit_strobe !== 1'b1) begin n_err++; $display("FAIL endrop_restart_strobe got=%b exp=1", bit_strobe); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL endrop_restart_level got=%0d exp=0", level); end
      for (int k = 0; k < 64; k++) begin
         n_cmp++; if (rf_data !== b1[3'(k/8)]) begin n_err++; $display("FAIL endrop_rf2 k=%0d got=%b exp=%b", k, rf_data, b1[3'(k/8)]); end
         n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL endrop_busy2 k=%0d got=%b exp=1", k, busy); end
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL endrop_done2 got=%b exp=1", done); end
      tick;
   endtask

   task automatic test_reset_mid_byte;
      logic [7:0] pat [4];
      logic [7:0] nb;
      pat[0] = 8'h3D; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      nb = 8'h4B;
      enable = 1'b1; baud_div = 16'd1;
      for (int i = 0; i < 4; i++) begin
         in_data = pat[i]; in_valid = 1'b1;
         tick;
      end
      in_valid = 1'b0;
      n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL rstmid_level_q got=%0d exp=3", level); end
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL rstmid_rf_bit1 got=%b exp=0", rf_data); end
      for (int i = 0; i < 8; i++) tick;
      n_cmp++; if (rf_data !== 1'b1) begin n_err++; $display("FAIL rstmid_rf_bit5 got=%b exp=1", rf_data); end
      n_cmp++; if (level !== 3'd3) begin n_err++; $display("FAIL rstmid_level_bit5 got=%0d exp=3", level); end
      rst = 1'b1;
      tick;
      rst = 1'b0;
      n_cmp++; if (rf_data !== 1'b0) begin n_err++; $display("FAIL rstmid_rf got=%b exp=0", rf_data); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      n_cmp++; if (level !== 3'd0) begin n_err++; $display("FAIL rstmid_level got=%0d exp=0", level); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done got=%b exp=0", done); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (bit_strobe !== 1'b0) begin n_err++; $display("FAIL rstmid_strobe got=%b exp=0", bit_strobe); end
      for (int i = 0; i < 6; i++) begin
         tick;
         n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_after_done i=%0d got=%b exp=0", i, done); end
         n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_after_busy i=%0d got=%b exp=0", i, busy); end
      end
      in_data = nb; in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      tick;
      for (int k = 0; k < 16; k++) begin
         n_cmp++; if (rf_data !== nb[3'(k/2)]) begin n_err++; $display("FAIL rstmid_new_rf k=%0d got=%b exp=%b", k, rf_data, nb[3'(k/2)]); end
         n_cmp++; if (bit_strobe !== (k % 2 == 0)) begin n_err++; $display("FAIL rstmid_new_strobe k=%0d got=%b exp=%b", k, bit_strobe, (k % 2 == 0)); end
         tick;
      end
      n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL rstmid_new_done got=%b exp=1", done); end
      tick;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_fifo_full;
      test_enable_drop;
      test_reset_mid_byte;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
